// File: rtl/ram_scalar.sv
// ram_scalar_ctrl: single-outstanding load/store front end for the ram_scalar data RAM.
// Absorbs the registered read latency and rejects out-of-range addresses before they reach the RAM.
module ram_scalar_ctrl #(
    parameter int unsigned          ADDR_W     = 24,
    parameter int unsigned          DATA_W     = 24,
    parameter int unsigned          RD_LATENCY = 2,
    parameter logic [ADDR_W-1:0]    ADDR_LIMIT = 24'h010000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_rden,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [2:0] cnt;
    logic       accept;
    logic       out_of_range;
    logic       read_done;

    assign accept       = req_valid && (state == IDLE);
    assign out_of_range = (req_addr >= ADDR_LIMIT);
    assign read_done    = (cnt == 3'(RD_LATENCY));

    // Handshake and RAM strobes come from the state register alone.
    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign ram_rden  = (state == READ);
    assign ram_wren  = (state == WRITE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (out_of_range) begin
                        next_state = RESP;
                    end else if (req_we) begin
                        next_state = WRITE;
                    end else begin
                        next_state = READ;
                    end
                end
            end
            READ: begin
                if (read_done) begin
                    next_state = RESP;
                end
            end
            WRITE: begin
                next_state = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // ram_address/ram_data double as the captured request; rejected requests leave them untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            ram_address <= '0;
            ram_data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt       <= '0;
                        rsp_rdata <= '0;
                        rsp_err   <= out_of_range;
                        if (!out_of_range) begin
                            ram_address <= req_addr;
                            if (req_we) begin
                                ram_data <= req_wdata;
                            end
                        end
                    end
                end
                READ: begin
                    cnt <= cnt + 3'd1;
                    if (read_done) begin
                        rsp_rdata <= ram_q;
                        rsp_err   <= 1'b0;
                    end
                end
                WRITE: begin
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_scalar_ctrl.sv
// Directed bench for ram_scalar_ctrl with a behavioural two-stage RAM and a response scoreboard.
module tb_ram_scalar_ctrl;

    localparam int unsigned AW  = 24;
    localparam int unsigned DW  = 24;
    localparam int unsigned LAT = 2;
    localparam logic [AW-1:0] LIMIT = 24'h010000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data;
    logic          ram_rden, ram_wren;
    logic [DW-1:0] ram_q;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic          err;
        logic [DW-1:0] rdata;
    } exp_t;
    exp_t exp_q[$];

    logic [DW-1:0] ram_mem [65536];
    logic [DW-1:0] ref_mem [65536];
    logic [DW-1:0] ram_s1;

    always #5 clk = ~clk;

    ram_scalar_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT), .ADDR_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_address(ram_address), .ram_data(ram_data),
        .ram_rden(ram_rden), .ram_wren(ram_wren), .ram_q(ram_q)
    );

    // Registered-read RAM: address sampled with rden, q valid two edges later.
    always @(posedge clk) begin
        if (ram_wren) ram_mem[ram_address[15:0]] <= ram_data;
        if (ram_rden) ram_s1 <= ram_mem[ram_address[15:0]];
        ram_q <= ram_s1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Scoreboard: a response is consumed on an edge where valid and ready are both high.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("strobe_excl", {31'd0, ram_rden & ram_wren}, 32'd0);
            chk("ready_only_idle", {31'd0, req_ready & (ram_rden | ram_wren | rsp_valid)}, 32'd0);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                    chk("rsp_rdata", {8'd0, rsp_rdata}, {8'd0, e.rdata});
                end
            end
        end
    end

    // Called #1 after a rising edge with the DUT idle; returns #1 after the edge raising rsp_valid.
    task automatic send(input string tag, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
        exp_t e;
        int   lat, nr, nw, want_lat;
        logic bad;
        bad = (a >= LIMIT);
        e.err   = bad;
        e.rdata = (bad || we) ? '0 : ref_mem[a[15:0]];
        if (!bad && we) ref_mem[a[15:0]] = d;
        want_lat = bad ? 0 : (we ? 1 : int'(LAT) + 1);
        chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        exp_q.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = ~we; req_addr = $urandom; req_wdata = $urandom;
        lat = -1; nr = 0; nw = 0;
        for (int n = 0; n < 20; n++) begin
            if (rsp_valid) begin lat = n; break; end
            if (ram_rden) begin
                nr++;
                chk({tag, "_rd_addr"}, {8'd0, ram_address}, {8'd0, a});
            end
            if (ram_wren) begin
                nw++;
                chk({tag, "_wr_addr"}, {8'd0, ram_address}, {8'd0, a});
                chk({tag, "_wr_data"}, {8'd0, ram_data}, {8'd0, d});
            end
            @(posedge clk); #1;
        end
        chk({tag, "_latency"}, lat, want_lat);
        chk({tag, "_rden_cycles"}, nr, (bad || we) ? 0 : LAT + 1);
        chk({tag, "_wren_cycles"}, nw, (!bad && we) ? 1 : 0);
    endtask

    task automatic finish_rsp(input string tag);
        @(posedge clk); #1;
        chk({tag, "_done_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_done_ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            ram_mem[i] = '0;
            ref_mem[i] = '0;
        end
        ram_s1 = '0; ram_q = '0;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b1;
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", {8'd0, rsp_rdata}, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_ram_addr", {8'd0, ram_address}, 32'd0);
        chk("rst_ram_data", {8'd0, ram_data}, 32'd0);
        chk("rst_strobes", {30'd0, ram_rden, ram_wren}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        send("st1000", 1'b1, 24'h001000, 24'habcdef);
        finish_rsp("st1000");
        send("ld1000", 1'b0, 24'h001000, 24'h000000);
        finish_rsp("ld1000");

        send("st1001", 1'b1, 24'h001001, 24'h123456);
        finish_rsp("st1001");
        send("ld1001", 1'b0, 24'h001001, 24'h000000);
        finish_rsp("ld1001");

        // Back-pressure: response held with a competing request presented.
        rsp_ready = 1'b0;
        send("bp", 1'b0, 24'h001001, 24'h000000);
        for (int i = 0; i < 10; i++) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = 24'h001000; req_wdata = 24'h555555;
            @(posedge clk); #1;
            chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rdata", {8'd0, rsp_rdata}, 32'h123456);
            chk("bp_ready", {31'd0, req_ready}, 32'd0);
            chk("bp_strobes", {30'd0, ram_rden, ram_wren}, 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        finish_rsp("bp");

        send("err_limit", 1'b0, LIMIT, 24'h000000);
        chk("err_flag", {31'd0, rsp_err}, 32'd1);
        chk("err_addr_held", {8'd0, ram_address}, 32'h001001);
        finish_rsp("err_limit");
        send("ld_ffff", 1'b0, LIMIT - 24'd1, 24'h000000);
        finish_rsp("ld_ffff");

        // Reset mid-read: the load's response is dropped.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 24'h001000;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #2;
        chk("mid_rden_before", {31'd0, ram_rden}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rden", {31'd0, ram_rden}, 32'd0);
        chk("mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("mid_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        send("ld_after_rst", 1'b0, 24'h001000, 24'h000000);
        finish_rsp("ld_after_rst");

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
